// File: rtl/usrt_rx_deframer.sv
// ---------------------------------------------------------------------------
// usrt_rx_deframer
//
// Receive-side deframer for a synchronous serial line. One bit is taken per
// qualified clock (i_BitEn=1). A frame is sent MSB first and is laid out as:
//    start(~IDLE_LVL), data[DATA_W-1]..data[0], parity, stop(IDLE_LVL)
// The parity bit is checked against the mode latched at the start bit, and
// the stop bit is checked against the idle level. The result is presented to
// the host as a one-cycle o_Valid pulse. o_Data and both error flags are held
// until the next frame completes.
//
// Ports
//    i_Pclk       system clock; all logic runs on its rising edge
//    i_Rst        synchronous reset, active-high
//    i_BitEn      bit strobe; i_SerIn is sampled only when this is 1
//    i_SerIn      serial line, already synchronous to i_Pclk
//    i_Parity     parity mode: 01 even, 10 odd, 00/11 none (slot not checked)
//    o_Data       received byte, held until the next frame completes
//    o_Valid      one-cycle pulse per completed frame
//    o_ParityErr  parity mismatch for the frame flagged by o_Valid
//    o_FrameErr   stop bit sampled as ~IDLE_LVL
//    o_Busy       high in any state other than IDLE
// ---------------------------------------------------------------------------
module usrt_rx_deframer #(
   parameter int   DATA_W   = 8,
   parameter logic IDLE_LVL = 1'b1
) (
   input  logic              i_Pclk,
   input  logic              i_Rst,
   input  logic              i_BitEn,
   input  logic              i_SerIn,
   input  logic [1:0]        i_Parity,
   output logic [DATA_W-1:0] o_Data,
   output logic              o_Valid,
   output logic              o_ParityErr,
   output logic              o_FrameErr,
   output logic              o_Busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   localparam logic [1:0] MODE_EVEN = 2'b01;
   localparam logic [1:0] MODE_ODD  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DATA      = 3'd1,
      S_PARITY    = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t              state_q,  state_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [DATA_W-1:0]   shift_q,  shift_d;
   logic [1:0]          mode_q,   mode_d;
   logic                par_q,    par_d;
   logic [DATA_W-1:0]   data_q,   data_d;
   logic                valid_q,  valid_d;
   logic                perr_q,   perr_d;
   logic                ferr_q,   ferr_d;

   // Parity the received data bits call for under the latched mode.
   logic data_xor;
   logic par_expected;
   logic par_checked;
   logic par_mismatch;

   always_comb begin
      data_xor     = ^shift_q;
      par_expected = (mode_q == MODE_ODD) ? ~data_xor : data_xor;
      par_checked  = (mode_q == MODE_EVEN) || (mode_q == MODE_ODD);
      par_mismatch = par_checked && (par_q != par_expected);
   end

   // Next-state and output logic. Nothing moves without a bit strobe, except
   // that o_Valid always falls back to 0 one cycle after it was raised.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      mode_d  = mode_q;
      par_d   = par_q;
      data_d  = data_q;
      valid_d = 1'b0;
      perr_d  = perr_q;
      ferr_d  = ferr_q;

      if (i_BitEn) begin
         unique case (state_q)
            S_IDLE: begin
               if (i_SerIn == ~IDLE_LVL) begin
                  // Mode is frozen for the whole frame at the start bit.
                  mode_d  = i_Parity;
                  cnt_d   = '0;
                  state_d = S_DATA;
               end
            end

            S_DATA: begin
               // MSB arrives first, so shifting into the LSB lines the byte up.
               shift_d = {shift_q[DATA_W-2:0], i_SerIn};
               if (cnt_q == LAST_BIT) begin
                  state_d = S_PARITY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_PARITY: begin
               par_d   = i_SerIn;
               state_d = S_STOP;
            end

            S_STOP: begin
               data_d  = shift_q;
               valid_d = 1'b1;
               perr_d  = par_mismatch;
               ferr_d  = (i_SerIn != IDLE_LVL);
               // A bad stop bit may be a break; wait for the line to return
               // to idle so a held line yields only one errored frame.
               state_d = (i_SerIn == IDLE_LVL) ? S_IDLE : S_WAIT_IDLE;
            end

            S_WAIT_IDLE: begin
               if (i_SerIn == IDLE_LVL) begin
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_Pclk) begin
      if (i_Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         mode_q  <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         mode_q  <= mode_d;
         par_q   <= par_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign o_Data      = data_q;
   assign o_Valid     = valid_q;
   assign o_ParityErr = perr_q;
   assign o_FrameErr  = ferr_q;
   assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_usrt_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_usrt_rx_deframer
//
// Directed bench for usrt_rx_deframer. Frames are driven bit by bit with
// hand-computed parity bits; a monitor records every o_Valid pulse together
// with the flags, the byte and the number of qualified edges seen so far.
// ---------------------------------------------------------------------------
module tb_usrt_rx_deframer;

   logic       clk;
   logic       rst;
   logic       bit_en;
   logic       ser_in;
   logic [1:0] par_mode;
   logic [7:0] data_o;
   logic       valid_o;
   logic       perr_o;
   logic       ferr_o;
   logic       busy_o;

   int checks = 0;
   int errors = 0;

   usrt_rx_deframer #(
      .DATA_W   (8),
      .IDLE_LVL (1'b1)
   ) dut (
      .i_Pclk      (clk),
      .i_Rst       (rst),
      .i_BitEn     (bit_en),
      .i_SerIn     (ser_in),
      .i_Parity    (par_mode),
      .o_Data      (data_o),
      .o_Valid     (valid_o),
      .o_ParityErr (perr_o),
      .o_FrameErr  (ferr_o),
      .o_Busy      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Qualified edge counter and o_Valid monitor.
   int         qcnt = 0;
   int         vcnt = 0;
   logic [7:0] cap_data [0:63];
   logic       cap_perr [0:63];
   logic       cap_ferr [0:63];
   int         cap_q    [0:63];

   always @(posedge clk) begin
      if (rst) qcnt <= 0;
      else if (bit_en) qcnt <= qcnt + 1;
   end

   always @(negedge clk) begin
      if (valid_o === 1'b1) begin
         cap_data[vcnt % 64] = data_o;
         cap_perr[vcnt % 64] = perr_o;
         cap_ferr[vcnt % 64] = ferr_o;
         cap_q[vcnt % 64]    = qcnt;
         vcnt = vcnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int gap_rot = 0;

   // Called at a falling edge; one strobe cycle then 'gap' idle cycles.
   // A negative gap rotates through 0..6 idle cycles (duty 1/1 .. 1/7).
   task automatic send_bit(input logic b, input int gap);
      int g;
      if (gap < 0) begin
         g = gap_rot;
         gap_rot = (gap_rot + 1) % 7;
      end else begin
         g = gap;
      end
      ser_in = b;
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      repeat (g) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                             input int gap, input logic [1:0] mode, input logic [1:0] mode_after);
      par_mode = mode;
      send_bit(1'b0, gap);
      par_mode = mode_after;
      for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
      send_bit(pbit, gap);
      send_bit(sbit, gap);
      ser_in = 1'b1;
   endtask

   task automatic idle(input int n);
      ser_in = 1'b1;
      bit_en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   int v0;
   int q0;

   initial begin
      rst      = 1'b1;
      bit_en   = 1'b0;
      ser_in   = 1'b1;
      par_mode = 2'b00;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_data",  {24'd0, data_o}, 32'h00);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_perr",  {31'd0, perr_o}, 32'd0);
      chk("rst_ferr",  {31'd0, ferr_o}, 32'd0);
      chk("rst_busy",  {31'd0, busy_o}, 32'd0);
      rst = 1'b0;
      idle(2);

      // Even 0xA5: four ones -> parity 0; one bit per 4 clocks
      v0 = vcnt; q0 = qcnt;
      send_frame(8'hA5, 1'b0, 1'b1, 3, 2'b01, 2'b01);
      idle(4);
      chk("a5_vcnt", vcnt - v0, 1);
      chk("a5_data", {24'd0, cap_data[v0 % 64]}, 32'hA5);
      chk("a5_perr", {31'd0, cap_perr[v0 % 64]}, 32'd0);
      chk("a5_ferr", {31'd0, cap_ferr[v0 % 64]}, 32'd0);
      chk("a5_latency", cap_q[v0 % 64] - q0, 11);
      chk("a5_hold", {24'd0, data_o}, 32'hA5);
      chk("a5_valid_low", {31'd0, valid_o}, 32'd0);
      chk("a5_busy_idle", {31'd0, busy_o}, 32'd0);

      // Odd 0x07: three ones -> odd parity bit 0
      v0 = vcnt;
      send_frame(8'h07, 1'b0, 1'b1, 1, 2'b10, 2'b10);
      idle(3);
      chk("o07_vcnt", vcnt - v0, 1);
      chk("o07_data", {24'd0, cap_data[v0 % 64]}, 32'h07);
      chk("o07_perr", {31'd0, cap_perr[v0 % 64]}, 32'd0);

      // Same frame with parity slot 1 -> parity error
      v0 = vcnt;
      send_frame(8'h07, 1'b1, 1'b1, 1, 2'b10, 2'b10);
      idle(3);
      chk("o07b_vcnt", vcnt - v0, 1);
      chk("o07b_data", {24'd0, cap_data[v0 % 64]}, 32'h07);
      chk("o07b_perr", {31'd0, cap_perr[v0 % 64]}, 32'd1);
      chk("o07b_ferr", {31'd0, cap_ferr[v0 % 64]}, 32'd0);

      // None mode 0x3C with parity slot 1 -> no error
      v0 = vcnt;
      send_frame(8'h3C, 1'b1, 1'b1, 0, 2'b00, 2'b00);
      idle(3);
      chk("n3c_data", {24'd0, cap_data[v0 % 64]}, 32'h3C);
      chk("n3c_perr", {31'd0, cap_perr[v0 % 64]}, 32'd0);

      // Mode switched to even after start bit: latched none still applies
      v0 = vcnt;
      send_frame(8'h3C, 1'b1, 1'b1, 2, 2'b00, 2'b01);
      idle(3);
      chk("n3cb_vcnt", vcnt - v0, 1);
      chk("n3cb_perr", {31'd0, cap_perr[v0 % 64]}, 32'd0);

      // Break: 0xFF (even parity 0) with bad stop, then line held low
      v0 = vcnt;
      par_mode = 2'b01;
      send_frame(8'hFF, 1'b0, 1'b0, 1, 2'b01, 2'b01);
      for (int i = 0; i < 30; i++) send_bit(1'b0, 1);
      chk("brk_vcnt", vcnt - v0, 1);
      chk("brk_data", {24'd0, cap_data[v0 % 64]}, 32'hFF);
      chk("brk_ferr", {31'd0, cap_ferr[v0 % 64]}, 32'd1);
      chk("brk_perr", {31'd0, cap_perr[v0 % 64]}, 32'd0);
      chk("brk_busy", {31'd0, busy_o}, 32'd1);
      send_bit(1'b1, 1);
      chk("brk_recover_busy", {31'd0, busy_o}, 32'd0);

      // 0x55 after recovery (four ones -> even parity 0)
      v0 = vcnt;
      send_frame(8'h55, 1'b0, 1'b1, 1, 2'b01, 2'b01);
      idle(3);
      chk("r55_vcnt", vcnt - v0, 1);
      chk("r55_data", {24'd0, cap_data[v0 % 64]}, 32'h55);
      chk("r55_ferr", {31'd0, cap_ferr[v0 % 64]}, 32'd0);

      // Back-to-back 0x12 (parity 0) then 0x34 (parity 1), varied strobe duty
      v0 = vcnt;
      send_frame(8'h12, 1'b0, 1'b1, -1, 2'b01, 2'b01);
      send_frame(8'h34, 1'b1, 1'b1, -1, 2'b01, 2'b01);
      idle(3);
      chk("b2b_vcnt", vcnt - v0, 2);
      chk("b2b_data0", {24'd0, cap_data[v0 % 64]}, 32'h12);
      chk("b2b_data1", {24'd0, cap_data[(v0 + 1) % 64]}, 32'h34);
      chk("b2b_spacing", cap_q[(v0 + 1) % 64] - cap_q[v0 % 64], 11);
      chk("b2b_perr1", {31'd0, cap_perr[(v0 + 1) % 64]}, 32'd0);

      // Reset after data bit 4 of 0x9A
      v0 = vcnt;
      par_mode = 2'b01;
      send_bit(1'b0, 1);
      send_bit(1'b1, 1);
      send_bit(1'b0, 1);
      send_bit(1'b0, 1);
      send_bit(1'b1, 1);
      chk("mid_busy", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_data", {24'd0, data_o}, 32'h00);
      chk("mrst_busy", {31'd0, busy_o}, 32'd0);
      chk("mrst_perr", {31'd0, perr_o}, 32'd0);
      chk("mrst_ferr", {31'd0, ferr_o}, 32'd0);
      // Remaining partial bits would look like data; keep line idle instead
      idle(5);
      chk("mrst_novalid", vcnt - v0, 0);
      send_frame(8'h9A, 1'b0, 1'b1, 1, 2'b01, 2'b01);
      idle(3);
      chk("m9a_vcnt", vcnt - v0, 1);
      chk("m9a_data", {24'd0, cap_data[v0 % 64]}, 32'h9A);
      chk("m9a_perr", {31'd0, cap_perr[v0 % 64]}, 32'd0);
      chk("m9a_ferr", {31'd0, cap_ferr[v0 % 64]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usrt_rx_deframer.md
Name: usrt_rx_deframer

Overview:
- Receive-side counterpart of the USRT transmit frame builder.
- Samples a serial line one bit per qualified clock and assembles the 11-bit frame, transmitted MSB first: start(0), data[7]..data[0], parity, stop(1).
- Checks parity (even/odd/none) and the stop bit, then presents the byte with error flags as a one-cycle valid pulse to the host side.

Parameters:
- DATA_W, 8, number of data bits per frame; frame length is DATA_W+3.
- IDLE_LVL, 1, line level treated as idle/stop; start bit is ~IDLE_LVL.

Ports:
- i_Pclk  input  1  system clock; all logic on its rising edge.
- i_Rst  input  1  synchronous reset, active-high.
- i_BitEn  input  1  bit strobe; i_SerIn is sampled only on edges where i_BitEn=1.
- i_SerIn  input  1  serial data line (already synchronous to i_Pclk).
- i_Parity  input  2  parity mode: 01 even, 10 odd, 00/11 none (bit slot present, not checked).
- o_Data  output  DATA_W  received byte, valid when o_Valid=1, held until the next frame completes.
- o_Valid  output  1  one-cycle pulse per completed frame.
- o_ParityErr  output  1  parity mismatch for the frame flagged by o_Valid; held with o_Data.
- o_FrameErr  output  1  stop bit sampled as ~IDLE_LVL; held with o_Data.
- o_Busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, i_Pclk. Reset is synchronous, active-high (i_Rst). Reset has priority over everything, including mid-frame, and returns to IDLE. Reset values: o_Data=0, o_Valid=0, o_ParityErr=0, o_FrameErr=0, o_Busy=0; shift register and bit counter cleared.
- Sampling: all state advances only on edges with i_BitEn=1. With i_BitEn=0 the state, counter and shift register hold, and o_Valid is 0 after the first cycle.
- IDLE:
  - Sample = ~IDLE_LVL: latch i_Parity into a per-frame mode register, clear the bit counter, go to DATA.
  - Otherwise stay in IDLE.
- DATA:
  - Shift the sample into the LSB of the shift register (MSB arrives first).
  - After DATA_W samples (counter 0..DATA_W-1), go to PARITY.
- PARITY:
  - Capture the sample as the parity bit, then go to STOP.
  - Expected value: even mode = XOR of data bits; odd mode = ~XOR of data bits; none = don't care (error forced 0).
- STOP, on the sampling edge:
  - o_Data <= shift register; o_Valid <= 1 for exactly one cycle.
  - o_ParityErr <= mismatch; o_FrameErr <= (sample != IDLE_LVL).
  - Next state: IDLE if the stop bit is good, WAIT_IDLE if it is bad.
- WAIT_IDLE (break/framing recovery): stay until a sample = IDLE_LVL, then go to IDLE. No start detection in this state, so a held-low line yields exactly one errored frame.
- Latency: o_Valid rises in the cycle after the edge that samples the stop bit, i.e. 11 qualified samples after the start sample edge.
- i_Parity changes mid-frame are ignored; the latched mode applies to the whole frame.
- Back-to-back frames: a start bit sampled on the first qualified edge after STOP is accepted, so zero idle bits are required between frames.
- Flags and o_Data update only at the STOP edge. The previous values hold through the next frame; there is no overrun detection (the host must consume within one frame).
- o_Busy = 1 in DATA, PARITY, STOP and WAIT_IDLE.

Test Plan:
- Even, 0xA5: i_Parity=01, bit sequence 0,1,0,1,0,0,1,0,1,0,1 at one bit per 4 clocks → single o_Valid pulse, o_Data=0xA5, o_ParityErr=0, o_FrameErr=0.
- Odd, 0x07: i_Parity=10, sequence 0,0,0,0,0,0,1,1,1,0,1 → o_Data=0x07, no errors. Same frame with parity slot 1 → o_ParityErr=1, o_Data still 0x07.
- None mode: i_Parity=00, 0x3C with parity slot driven 1 → o_ParityErr=0. Change i_Parity to 01 after the start bit → still no parity error.
- Framing/break: 0xFF frame with stop slot 0, then line held 0 for 30 bits → one o_Valid with o_FrameErr=1, no further o_Valid. The line returns to 1 then frame 0x55 → o_Valid, o_Data=0x55, o_FrameErr=0.
- Back-to-back and strobe gaps: frames 0x12 then 0x34 with no idle bit, i_BitEn duty varied 1/1 to 1/7 → two o_Valid pulses, exactly 11 qualified samples apart, correct bytes.
- Reset mid-frame: assert i_Rst for 1 cycle after data bit 4 of 0x9A → all outputs 0, o_Busy=0. A subsequent full 0x9A frame decodes correctly and the partial frame produces no o_Valid.
